// File: rtl/ldpc_dec.sv
// Hard-decision LDPC decoder core: captures per-slot LLR sign bits, waits an
// iteration budget, then streams the information-slot hard decisions out.
module ldpc_dec #(
  parameter int ZC              = 4,
  parameter int VWIDTH          = 8,
  parameter int DEC_OUT_LIFTING = 8,
  parameter int APP_ADDR_WIDTH  = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ZC*VWIDTH-1:0]          APPmsg_ini_subx_0,
  input  logic [ZC*VWIDTH-1:0]          APPmsg_ini_subx_1,
  input  logic [ZC*VWIDTH-1:0]          APPmsg_ini_subx_2,
  input  logic [ZC*VWIDTH-1:0]          APPmsg_ini_subx_3,
  input  logic [ZC*VWIDTH-1:0]          APPmsg_ini_subx_4,
  input  logic [ZC*VWIDTH-1:0]          APPmsg_ini_subx_5,
  input  logic [ZC*VWIDTH-1:0]          APPmsg_ini_subx_6,
  input  logic [ZC*VWIDTH-1:0]          APPmsg_ini_subx_7,
  input  logic [1:0]                    APPmsg_ini_sub_x,
  input  logic                          buffer_valid,
  input  logic                          buffer_start,
  input  logic                          buffer_last,
  input  logic [2:0]                    iLs,
  input  logic [2:0]                    jLs,
  input  logic [5:0]                    P,
  input  logic [APP_ADDR_WIDTH-1:0]     APP_addr_max,
  input  logic [APP_ADDR_WIDTH-2:0]     APP_addr_rd_max,
  output logic                          buffer_ready,
  output logic                          decode_valid,
  output logic [2:0]                    decode_valid_cnt,
  output logic [ZC*DEC_OUT_LIFTING-1:0] APPmsg_decode_out
);

  localparam int SLOT_W = ZC * DEC_OUT_LIFTING;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_DECODE = 2'd2;
  localparam logic [1:0] S_OUTPUT = 2'd3;

  logic [1:0]                state_q, state_d;
  logic [2:0]                ils_q, ils_d;
  logic [2:0]                jls_q, jls_d;
  logic [5:0]                p_q, p_d;
  logic [APP_ADDR_WIDTH-1:0] addr_max_q, addr_max_d;
  logic [APP_ADDR_WIDTH-2:0] addr_rd_max_q, addr_rd_max_d;
  logic [8:0]                dec_cnt_q, dec_cnt_d;
  logic [SLOT_W-1:0]         slot_q [4];
  logic [SLOT_W-1:0]         slot_d [4];
  logic                      dv_q, dv_d;
  logic [2:0]                vcnt_q, vcnt_d;
  logic [SLOT_W-1:0]         dout_q, dout_d;

  logic [ZC*VWIDTH-1:0] col [8];
  logic [SLOT_W-1:0]    hard;
  logic [5:0]           p_eff;
  logic [2:0]           j_eff;
  logic [8:0]           dec_len;
  logic [2:0]           last_beat;
  logic [1:0]           nxt_slot;
  logic                 unused_reserved;

  assign col[0] = APPmsg_ini_subx_0;
  assign col[1] = APPmsg_ini_subx_1;
  assign col[2] = APPmsg_ini_subx_2;
  assign col[3] = APPmsg_ini_subx_3;
  assign col[4] = APPmsg_ini_subx_4;
  assign col[5] = APPmsg_ini_subx_5;
  assign col[6] = APPmsg_ini_subx_6;
  assign col[7] = APPmsg_ini_subx_7;

  // Hard decision is the LLR sign bit, so a zero LLR decides 0.
  always_comb begin
    hard = '0;
    for (int c = 0; c < DEC_OUT_LIFTING; c++) begin
      for (int z = 0; z < ZC; z++) begin
        hard[c*ZC+z] = col[c][z*VWIDTH+VWIDTH-1];
      end
    end
  end

  // A zero budget or multiplier still costs one pass.
  assign p_eff     = (p_q == 6'd0) ? 6'd1 : p_q;
  assign j_eff     = (jls_q == 3'd0) ? 3'd1 : jls_q;
  assign dec_len   = 9'(p_eff) * 9'(j_eff);
  assign last_beat = (ils_q == 3'd2) ? 3'd1 : 3'd2;
  assign nxt_slot  = vcnt_q[1:0] + 2'd1;

  assign unused_reserved = ^{addr_max_q, addr_rd_max_q};

  always_comb begin
    state_d       = state_q;
    ils_d         = ils_q;
    jls_d         = jls_q;
    p_d           = p_q;
    addr_max_d    = addr_max_q;
    addr_rd_max_d = addr_rd_max_q;
    dec_cnt_d     = dec_cnt_q;
    slot_d        = slot_q;
    dv_d          = 1'b0;
    vcnt_d        = 3'd0;
    dout_d        = '0;
    case (state_q)
      S_IDLE: begin
        dec_cnt_d = 9'd0;
        if (buffer_start) begin
          state_d       = S_LOAD;
          ils_d         = iLs;
          jls_d         = jLs;
          p_d           = P;
          addr_max_d    = APP_addr_max;
          addr_rd_max_d = APP_addr_rd_max;
        end
      end
      S_LOAD: begin
        if (buffer_valid) begin
          slot_d[APPmsg_ini_sub_x] = hard;
          if (buffer_last) begin
            state_d   = S_DECODE;
            dec_cnt_d = 9'd0;
          end
        end
      end
      S_DECODE: begin
        // The extra compare cycle places the first beat at last + D + 1.
        if (dec_cnt_q == dec_len) begin
          state_d = S_OUTPUT;
          dv_d    = 1'b1;
          vcnt_d  = 3'd0;
          dout_d  = slot_q[0];
        end else begin
          dec_cnt_d = dec_cnt_q + 9'd1;
        end
      end
      default: begin
        if (vcnt_q == last_beat) begin
          state_d = S_IDLE;
        end else begin
          dv_d   = 1'b1;
          vcnt_d = vcnt_q + 3'd1;
          dout_d = slot_q[nxt_slot];
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q       <= S_IDLE;
      ils_q         <= '0;
      jls_q         <= '0;
      p_q           <= '0;
      addr_max_q    <= '0;
      addr_rd_max_q <= '0;
      dec_cnt_q     <= '0;
      for (int s = 0; s < 4; s++) slot_q[s] <= '0;
      dv_q          <= 1'b0;
      vcnt_q        <= '0;
      dout_q        <= '0;
    end else begin
      state_q       <= state_d;
      ils_q         <= ils_d;
      jls_q         <= jls_d;
      p_q           <= p_d;
      addr_max_q    <= addr_max_d;
      addr_rd_max_q <= addr_rd_max_d;
      dec_cnt_q     <= dec_cnt_d;
      for (int s = 0; s < 4; s++) slot_q[s] <= slot_d[s];
      dv_q          <= dv_d;
      vcnt_q        <= vcnt_d;
      dout_q        <= dout_d;
    end
  end

  assign buffer_ready      = (state_q == S_IDLE);
  assign decode_valid      = dv_q;
  assign decode_valid_cnt  = vcnt_q;
  assign APPmsg_decode_out = dout_q;

endmodule

// File: tb/tb_ldpc_dec.sv
// Scoreboard bench for ldpc_dec: a sign-bit slot model predicts each output
// beat (index, data, arrival cycle); a monitor pops and compares.
module tb_ldpc_dec;
  localparam int ZC = 4;
  localparam int VW = 8;
  localparam int DOL = 8;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst_n;
  logic [ZC*VW-1:0] subx [8];
  logic [1:0]  sub_x;
  logic        valid, start, last;
  logic [2:0]  ils, jls;
  logic [5:0]  p;
  logic [AW-1:0] amax;
  logic [AW-2:0] armax;
  logic        buffer_ready, decode_valid;
  logic [2:0]  decode_valid_cnt;
  logic [ZC*DOL-1:0] dout;

  always #5 clk = ~clk;

  ldpc_dec #(.ZC(ZC), .VWIDTH(VW), .DEC_OUT_LIFTING(DOL), .APP_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .APPmsg_ini_subx_0(subx[0]), .APPmsg_ini_subx_1(subx[1]),
    .APPmsg_ini_subx_2(subx[2]), .APPmsg_ini_subx_3(subx[3]),
    .APPmsg_ini_subx_4(subx[4]), .APPmsg_ini_subx_5(subx[5]),
    .APPmsg_ini_subx_6(subx[6]), .APPmsg_ini_subx_7(subx[7]),
    .APPmsg_ini_sub_x(sub_x), .buffer_valid(valid), .buffer_start(start),
    .buffer_last(last), .iLs(ils), .jLs(jls), .P(p),
    .APP_addr_max(amax), .APP_addr_rd_max(armax),
    .buffer_ready(buffer_ready), .decode_valid(decode_valid),
    .decode_valid_cnt(decode_valid_cnt), .APPmsg_decode_out(dout)
  );

  typedef struct {
    int          cnt;
    logic [31:0] data;
    int          at;
    bit          lastb;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          ready_chk_at = -1;
  logic [31:0] m_slot [4];
  int          m_ils, m_jls, m_p;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every output beat must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      if (decode_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat @cyc %0d: got cnt %0d data %h expected no beat",
                   cyc, decode_valid_cnt, dout);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("beat_cnt", 64'(decode_valid_cnt), 64'(e.cnt));
          check("beat_data", 64'(dout), 64'(e.data));
          check("beat_cycle", 64'(cyc), 64'(e.at));
          check("ready_low_in_output", 64'(buffer_ready), 64'd0);
          if (e.lastb) ready_chk_at = cyc + 1;
        end
      end else begin
        check("idle_outputs_zero", {29'd0, decode_valid_cnt, dout}, 64'd0);
      end
      if (cyc == ready_chk_at) check("ready_after_burst", 64'(buffer_ready), 64'd1);
    end
  end

  function automatic logic [31:0] model_hard();
    logic [31:0] r;
    logic signed [7:0] v;
    r = '0;
    for (int c = 0; c < 8; c++) begin
      for (int z = 0; z < ZC; z++) begin
        v = subx[c][z*VW +: VW];
        r[c*ZC+z] = (v < 0);
      end
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [7:0] v);
    for (int k = 0; k < 8; k++) subx[k] = {4{v}};
  endtask

  task automatic set_rand();
    for (int k = 0; k < 8; k++) subx[k] = $urandom;
  endtask

  task automatic push_exp(input int t);
    int d, n;
    d = ((m_p == 0) ? 1 : m_p) * ((m_jls == 0) ? 1 : m_jls);
    n = (m_ils == 2) ? 2 : 3;
    for (int b = 0; b < n; b++) q.push_back('{b, m_slot[b], t + d + 1 + b, (b == n - 1)});
  endtask

  task automatic start_frame(input int i, input int j, input int pp);
    ils = 3'(i); jls = 3'(j); p = 6'(pp);
    amax = 6'($urandom); armax = 5'($urandom);
    start = 1'b1;
    step();
    start = 1'b0;
    m_ils = i; m_jls = j; m_p = pp;
    // Scramble mode inputs so only the values latched at start may matter.
    ils = 3'($urandom); jls = 3'($urandom); p = 6'($urandom);
  endtask

  task automatic beat(input int sub, input bit lst);
    sub_x = 2'(sub); valid = 1'b1; last = lst;
    step();
    m_slot[sub] = model_hard();
    if (lst) push_exp(cyc);
    valid = 1'b0; last = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while ((q.size() != 0 || !buffer_ready) && k < 3000) begin
      step();
      k++;
    end
    step();
    step();
    check("frame_drained", 64'(k < 3000), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; valid = 0; start = 0; last = 0; sub_x = 0;
    ils = 0; jls = 0; p = 0; amax = 0; armax = 0;
    set_all(8'h00);
    for (int s = 0; s < 4; s++) m_slot[s] = '0;
    m_ils = 0; m_jls = 0; m_p = 0;
    step(); step();
    check("rst_ready", 64'(buffer_ready), 64'd1);
    check("rst_valid", 64'(decode_valid), 64'd0);
    check("rst_out", {29'd0, decode_valid_cnt, dout}, 64'd0);
    rst_n = 1'b0;
    step(); step();
    check("post_rst_ready", 64'(buffer_ready), 64'd1);
    check("post_rst_valid", 64'(decode_valid), 64'd0);
    check("post_rst_out", {29'd0, decode_valid_cnt, dout}, 64'd0);

    // Rate 2/3, P=32, jLs=1, 16 beats per slot.
    start_frame(0, 1, 32);
    check("ready_low_in_load", 64'(buffer_ready), 64'd0);
    for (int s = 0; s < 4; s++) begin
      set_all((s == 0 || s == 2) ? 8'hF0 : 8'h10);
      for (int i = 0; i < 16; i++) beat(s, (s == 3) && (i == 15));
    end
    wait_done();

    // Rate 7/8 with alternating sign per lift in slot 0.
    start_frame(2, 1, 3);
    for (int k = 0; k < 8; k++) subx[k] = {8'h7F, 8'h80, 8'h7F, 8'h80};
    beat(0, 0);
    set_rand(); beat(1, 0);
    set_rand(); beat(2, 1);
    wait_done();

    // Overwrite, zero LLR, P=5 jLs=2.
    start_frame(1, 2, 5);
    set_all(8'h00); beat(0, 0);
    set_all(8'hFF); beat(1, 0);
    set_all(8'h01); beat(1, 0);
    set_rand(); beat(2, 1);
    wait_done();

    // Zero budget and multiplier.
    start_frame(3, 0, 0);
    for (int s = 0; s < 4; s++) begin
      set_rand(); beat(s, s == 3);
    end
    wait_done();

    // A start pulse during decode must not trigger a second burst.
    start_frame(0, 1, 20);
    for (int s = 0; s < 3; s++) begin
      set_rand(); beat(s, s == 2);
    end
    step(); step(); step();
    ils = 3'd2; start = 1'b1;
    step();
    start = 1'b0;
    wait_done();

    // Reset mid-load aborts the frame and clears the slot store.
    start_frame(0, 1, 4);
    set_rand(); beat(0, 0);
    set_rand(); beat(1, 0);
    rst_n = 1'b1;
    #1;
    check("abort_ready", 64'(buffer_ready), 64'd1);
    check("abort_valid", 64'(decode_valid), 64'd0);
    for (int s = 0; s < 4; s++) m_slot[s] = '0;
    step(); step();
    rst_n = 1'b0;
    step();
    start_frame(0, 2, 3);
    set_rand(); beat(0, 0);
    set_rand(); beat(2, 1);
    wait_done();

    // Randomised frames with gaps, stray idle beats and unqualified last.
    repeat (10) begin
      int nb, md;
      set_rand(); sub_x = 2'($urandom); valid = 1'b1;
      step();
      valid = 1'b0;
      md = ($urandom_range(0, 1) == 1) ? 2 : $urandom_range(0, 7);
      start_frame(md, $urandom_range(0, 7), $urandom_range(0, 12));
      nb = $urandom_range(1, 8);
      for (int b = 0; b < nb; b++) begin
        repeat ($urandom_range(0, 2)) begin
          last = $urandom_range(0, 1);
          step();
          last = 1'b0;
        end
        set_rand();
        beat($urandom_range(0, 3), b == nb - 1);
      end
      wait_done();
    end

    check("queue_empty", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
